// File: rtl/game_pkg.sv
// Shared game definitions: PS/2 set-2 key codes, blank digit value and the
// move-entry state encoding, reused by the display and board blocks.
package game_pkg;

  localparam logic [3:0] BLANK = 4'd15;

  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_B = 8'h32;
  localparam logic [7:0] KEY_C = 8'h21;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_E = 8'h24;
  localparam logic [7:0] KEY_F = 8'h2B;
  localparam logic [7:0] KEY_G = 8'h34;
  localparam logic [7:0] KEY_H = 8'h33;
  localparam logic [7:0] KEY_I = 8'h43;
  localparam logic [7:0] KEY_J = 8'h3B;

  localparam logic [7:0] KEY_0 = 8'h45;
  localparam logic [7:0] KEY_1 = 8'h16;
  localparam logic [7:0] KEY_2 = 8'h1E;
  localparam logic [7:0] KEY_3 = 8'h26;
  localparam logic [7:0] KEY_4 = 8'h25;
  localparam logic [7:0] KEY_5 = 8'h2E;
  localparam logic [7:0] KEY_6 = 8'h36;
  localparam logic [7:0] KEY_7 = 8'h3D;
  localparam logic [7:0] KEY_8 = 8'h3E;
  localparam logic [7:0] KEY_9 = 8'h46;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef enum logic [2:0] {
    WAIT_LETTER  = 3'd0,
    WAIT_NUMBER  = 3'd1,
    WAIT_CONFIRM = 3'd2,
    ISSUE        = 3'd3,
    LOCKED       = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    KC_NONE   = 3'd0,
    KC_LETTER = 3'd1,
    KC_DIGIT  = 3'd2,
    KC_ENTER  = 3'd3,
    KC_BKSP   = 3'd4,
    KC_ESC    = 3'd5
  } key_class_t;

endpackage

// File: rtl/key_decoder.sv
// Combinational PS/2 make-code classifier: key class plus the column/row
// value carried by letter and digit keys (0 for every other class).
module key_decoder
  import game_pkg::*;
(
  input  logic [7:0] key_code,
  output logic [2:0] key_class,
  output logic [3:0] key_value
);

  always_comb begin
    key_class = KC_NONE;
    key_value = 4'd0;
    case (key_code)
      KEY_A: begin key_class = KC_LETTER; key_value = 4'd0; end
      KEY_B: begin key_class = KC_LETTER; key_value = 4'd1; end
      KEY_C: begin key_class = KC_LETTER; key_value = 4'd2; end
      KEY_D: begin key_class = KC_LETTER; key_value = 4'd3; end
      KEY_E: begin key_class = KC_LETTER; key_value = 4'd4; end
      KEY_F: begin key_class = KC_LETTER; key_value = 4'd5; end
      KEY_G: begin key_class = KC_LETTER; key_value = 4'd6; end
      KEY_H: begin key_class = KC_LETTER; key_value = 4'd7; end
      KEY_I: begin key_class = KC_LETTER; key_value = 4'd8; end
      KEY_J: begin key_class = KC_LETTER; key_value = 4'd9; end
      KEY_0: begin key_class = KC_DIGIT;  key_value = 4'd0; end
      KEY_1: begin key_class = KC_DIGIT;  key_value = 4'd1; end
      KEY_2: begin key_class = KC_DIGIT;  key_value = 4'd2; end
      KEY_3: begin key_class = KC_DIGIT;  key_value = 4'd3; end
      KEY_4: begin key_class = KC_DIGIT;  key_value = 4'd4; end
      KEY_5: begin key_class = KC_DIGIT;  key_value = 4'd5; end
      KEY_6: begin key_class = KC_DIGIT;  key_value = 4'd6; end
      KEY_7: begin key_class = KC_DIGIT;  key_value = 4'd7; end
      KEY_8: begin key_class = KC_DIGIT;  key_value = 4'd8; end
      KEY_9: begin key_class = KC_DIGIT;  key_value = 4'd9; end
      KEY_ENTER: key_class = KC_ENTER;
      KEY_BKSP:  key_class = KC_BKSP;
      KEY_ESC:   key_class = KC_ESC;
      default: ;
    endcase
  end

endmodule

// File: rtl/move_entry_controller.sv
// Keyboard move entry: collects a letter/number pair, confirms it with ENTER
// and holds moveReq until the board acknowledges or the ack timeout expires.
module move_entry_controller
  import game_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic       clock27,
  input  logic       resetN,
  input  logic       keyValid,
  input  logic [7:0] keyCode,
  input  logic       gameOver,
  input  logic       moveAck,
  input  logic       moveHit,
  output logic       moveReq,
  output logic [3:0] letter,
  output logic [3:0] number,
  output logic       playerTurn,
  output logic       hitFlag,
  output logic       timeoutErr,
  output logic [2:0] stateDbg
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic             armed_q;
  logic             req_n, turn_n, hit_n, terr_n;
  logic [3:0]       letter_n, number_n;
  logic [2:0]       key_class;
  logic [3:0]       key_value;
  logic             key_ok, key_taken, in_entry;

  key_decoder u_key_decoder (
    .key_code  (keyCode),
    .key_class (key_class),
    .key_value (key_value)
  );

  // armed_q keeps the first edge after reset release from accepting a key;
  // a key arriving together with an ack is always dropped.
  assign key_ok   = keyValid && !moveAck && armed_q;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign in_entry = (state_q == WAIT_LETTER) || (state_q == WAIT_NUMBER) ||
                    (state_q == WAIT_CONFIRM);
  assign stateDbg = state_q;

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    req_n     = moveReq;
    letter_n  = letter;
    number_n  = number;
    turn_n    = playerTurn;
    hit_n     = hitFlag;
    terr_n    = timeoutErr;
    key_taken = 1'b0;

    if (gameOver) begin
      state_n = LOCKED;
      req_n   = 1'b0;
    end else begin
      case (state_q)
        WAIT_LETTER: begin
          if (key_ok && key_class == KC_LETTER) begin
            letter_n  = key_value;
            state_n   = WAIT_NUMBER;
            key_taken = 1'b1;
          end
        end
        WAIT_NUMBER: begin
          if (key_ok && key_class == KC_DIGIT) begin
            number_n  = key_value;
            state_n   = WAIT_CONFIRM;
            key_taken = 1'b1;
          end else if (key_ok && key_class == KC_BKSP) begin
            letter_n  = BLANK;
            state_n   = WAIT_LETTER;
            key_taken = 1'b1;
          end
        end
        WAIT_CONFIRM: begin
          if (key_ok && key_class == KC_ENTER) begin
            req_n     = 1'b1;
            cnt_n     = '0;
            state_n   = ISSUE;
            key_taken = 1'b1;
          end else if (key_ok && key_class == KC_BKSP) begin
            number_n  = BLANK;
            state_n   = WAIT_NUMBER;
            key_taken = 1'b1;
          end
        end
        ISSUE: begin
          // An ack on the limit cycle wins over the timeout.
          if (moveAck) begin
            req_n    = 1'b0;
            hit_n    = moveHit;
            turn_n   = ~playerTurn;
            letter_n = BLANK;
            number_n = BLANK;
            state_n  = WAIT_LETTER;
          end else if (cnt_inc == CNT_LIMIT) begin
            req_n   = 1'b0;
            terr_n  = 1'b1;
            cnt_n   = cnt_inc;
            state_n = WAIT_CONFIRM;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        LOCKED: ;
        default: state_n = WAIT_LETTER;
      endcase

      if (key_ok && in_entry && key_class == KC_ESC) begin
        letter_n  = BLANK;
        number_n  = BLANK;
        state_n   = WAIT_LETTER;
        key_taken = 1'b1;
      end

      if (key_taken) terr_n = 1'b0;
    end
  end

  always_ff @(posedge clock27 or negedge resetN) begin
    if (!resetN) begin
      state_q    <= WAIT_LETTER;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      moveReq    <= 1'b0;
      letter     <= BLANK;
      number     <= BLANK;
      playerTurn <= 1'b0;
      hitFlag    <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      armed_q    <= 1'b1;
      moveReq    <= req_n;
      letter     <= letter_n;
      number     <= number_n;
      playerTurn <= turn_n;
      hitFlag    <= hit_n;
      timeoutErr <= terr_n;
    end
  end

endmodule

// File: tb/tb_move_entry_controller.sv
// Directed table-driven bench for move_entry_controller with ACK_TIMEOUT=8;
// asynchronous reset behaviour is exercised by hand-written sequences.
module tb_move_entry_controller;
  import game_pkg::*;

  logic       clock27 = 1'b0;
  logic       resetN = 1'b0;
  logic       keyValid = 1'b0;
  logic [7:0] keyCode = 8'h00;
  logic       gameOver = 1'b0;
  logic       moveAck = 1'b0;
  logic       moveHit = 1'b0;
  logic       moveReq;
  logic [3:0] letter, number;
  logic       playerTurn, hitFlag, timeoutErr;
  logic [2:0] stateDbg;

  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    string      name;
    logic       kv;
    logic [7:0] kc;
    logic       ack, hit, go;
    logic       e_req;
    logic [3:0] e_let, e_num;
    logic       e_turn, e_hit, e_terr;
    logic [2:0] e_st;
  } vec_t;

  vec_t vecs[$];

  move_entry_controller #(.ACK_TIMEOUT(8)) dut (
    .clock27    (clock27),
    .resetN     (resetN),
    .keyValid   (keyValid),
    .keyCode    (keyCode),
    .gameOver   (gameOver),
    .moveAck    (moveAck),
    .moveHit    (moveHit),
    .moveReq    (moveReq),
    .letter     (letter),
    .number     (number),
    .playerTurn (playerTurn),
    .hitFlag    (hitFlag),
    .timeoutErr (timeoutErr),
    .stateDbg   (stateDbg)
  );

  always #5 clock27 = ~clock27;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic e_req,
                       input logic [3:0] e_let, input logic [3:0] e_num,
                       input logic e_turn, input logic e_hit, input logic e_terr,
                       input logic [2:0] e_st);
    logic [14:0] act, exp;
    act = {moveReq, letter, number, playerTurn, hitFlag, timeoutErr, stateDbg};
    exp = {e_req, e_let, e_num, e_turn, e_hit, e_terr, e_st};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got req=%b let=%0d num=%0d turn=%b hit=%b terr=%b st=%0d, expected req=%b let=%0d num=%0d turn=%b hit=%b terr=%b st=%0d",
               name, moveReq, letter, number, playerTurn, hitFlag, timeoutErr, stateDbg,
               e_req, e_let, e_num, e_turn, e_hit, e_terr, e_st);
    end
  endtask

  task automatic add(input string name, input logic kv, input logic [7:0] kc,
                     input logic ack, input logic hit, input logic go,
                     input logic e_req, input logic [3:0] e_let, input logic [3:0] e_num,
                     input logic e_turn, input logic e_hit, input logic e_terr,
                     input state_t e_st);
    vec_t v;
    v.name = name; v.kv = kv; v.kc = kc; v.ack = ack; v.hit = hit; v.go = go;
    v.e_req = e_req; v.e_let = e_let; v.e_num = e_num; v.e_turn = e_turn;
    v.e_hit = e_hit; v.e_terr = e_terr; v.e_st = e_st;
    vecs.push_back(v);
  endtask

  // Inputs are driven 1 time unit after a rising edge and checked 1 unit after the next.
  task automatic run_all();
    foreach (vecs[i]) begin
      keyValid = vecs[i].kv;
      keyCode  = vecs[i].kc;
      moveAck  = vecs[i].ack;
      moveHit  = vecs[i].hit;
      gameOver = vecs[i].go;
      @(posedge clock27);
      #1;
      check(vecs[i].name, vecs[i].e_req, vecs[i].e_let, vecs[i].e_num,
            vecs[i].e_turn, vecs[i].e_hit, vecs[i].e_terr, vecs[i].e_st);
    end
    keyValid = 1'b0; keyCode = 8'h00; moveAck = 1'b0; moveHit = 1'b0; gameOver = 1'b0;
    vecs.delete();
  endtask

  initial begin
    repeat (3) @(posedge clock27);
    #1;
    check("reset_values", 0, 15, 15, 0, 0, 0, WAIT_LETTER);
    resetN = 1'b1;

    // name                  kv kc     ack hit go  req let num trn hit err state
    add("release_cycle_key", 1, 8'h24, 0, 0, 0,   0, 15, 15, 0, 0, 0, WAIT_LETTER);
    add("a_letter_e",        1, 8'h24, 0, 0, 0,   0,  4, 15, 0, 0, 0, WAIT_NUMBER);
    add("a_digit_5",         1, 8'h2E, 0, 0, 0,   0,  4,  5, 0, 0, 0, WAIT_CONFIRM);
    add("a_enter",           1, 8'h5A, 0, 0, 0,   1,  4,  5, 0, 0, 0, ISSUE);
    add("a_wait",            0, 8'h00, 0, 0, 0,   1,  4,  5, 0, 0, 0, ISSUE);
    add("a_key_in_issue",    1, 8'h66, 0, 0, 0,   1,  4,  5, 0, 0, 0, ISSUE);
    for (int i = 0; i < 3; i++)
      add("a_wait",          0, 8'h00, 0, 0, 0,   1,  4,  5, 0, 0, 0, ISSUE);
    add("a_ack_hit",         0, 8'h00, 1, 1, 0,   0, 15, 15, 1, 1, 0, WAIT_LETTER);

    add("b_letter_a",        1, 8'h1C, 0, 0, 0,   0,  0, 15, 1, 1, 0, WAIT_NUMBER);
    add("b_digit_1",         1, 8'h16, 0, 0, 0,   0,  0,  1, 1, 1, 0, WAIT_CONFIRM);
    add("b_bksp_number",     1, 8'h66, 0, 0, 0,   0,  0, 15, 1, 1, 0, WAIT_NUMBER);
    add("b_bksp_letter",     1, 8'h66, 0, 0, 0,   0, 15, 15, 1, 1, 0, WAIT_LETTER);
    add("b_enter_in_wl",     1, 8'h5A, 0, 0, 0,   0, 15, 15, 1, 1, 0, WAIT_LETTER);
    add("b_digit_in_wl",     1, 8'h45, 0, 0, 0,   0, 15, 15, 1, 1, 0, WAIT_LETTER);

    add("e_letter_j",        1, 8'h3B, 0, 0, 0,   0,  9, 15, 1, 1, 0, WAIT_NUMBER);
    add("e_letter_in_wn",    1, 8'h1C, 0, 0, 0,   0,  9, 15, 1, 1, 0, WAIT_NUMBER);
    add("e_digit_9",         1, 8'h46, 0, 0, 0,   0,  9,  9, 1, 1, 0, WAIT_CONFIRM);
    add("e_letter_in_wc",    1, 8'h43, 0, 0, 0,   0,  9,  9, 1, 1, 0, WAIT_CONFIRM);
    add("e_digit_in_wc",     1, 8'h3E, 0, 0, 0,   0,  9,  9, 1, 1, 0, WAIT_CONFIRM);
    add("e_esc",             1, 8'h76, 0, 0, 0,   0, 15, 15, 1, 1, 0, WAIT_LETTER);

    add("c_letter_c",        1, 8'h21, 0, 0, 0,   0,  2, 15, 1, 1, 0, WAIT_NUMBER);
    add("c_digit_7",         1, 8'h3D, 0, 0, 0,   0,  2,  7, 1, 1, 0, WAIT_CONFIRM);
    add("c_enter",           1, 8'h5A, 0, 0, 0,   1,  2,  7, 1, 1, 0, ISSUE);
    for (int i = 0; i < 7; i++)
      add("c_wait_no_ack",   0, 8'h00, 0, 0, 0,   1,  2,  7, 1, 1, 0, ISSUE);
    add("c_timeout",         0, 8'h00, 0, 0, 0,   0,  2,  7, 1, 1, 1, WAIT_CONFIRM);
    add("c_unknown_key",     1, 8'h00, 0, 0, 0,   0,  2,  7, 1, 1, 1, WAIT_CONFIRM);
    add("c_reenter",         1, 8'h5A, 0, 0, 0,   1,  2,  7, 1, 1, 0, ISSUE);
    add("d_key_with_ack",    1, 8'h1C, 1, 0, 0,   0, 15, 15, 0, 0, 0, WAIT_LETTER);
    add("d_ack_outside",     0, 8'h00, 1, 1, 0,   0, 15, 15, 0, 0, 0, WAIT_LETTER);

    add("f_letter_d",        1, 8'h23, 0, 0, 0,   0,  3, 15, 0, 0, 0, WAIT_NUMBER);
    add("f_digit_3",         1, 8'h26, 0, 0, 0,   0,  3,  3, 0, 0, 0, WAIT_CONFIRM);
    add("f_enter",           1, 8'h5A, 0, 0, 0,   1,  3,  3, 0, 0, 0, ISSUE);
    for (int i = 0; i < 7; i++)
      add("f_wait",          0, 8'h00, 0, 0, 0,   1,  3,  3, 0, 0, 0, ISSUE);
    add("f_ack_at_limit",    0, 8'h00, 1, 1, 0,   0, 15, 15, 1, 1, 0, WAIT_LETTER);

    add("g_letter_e",        1, 8'h24, 0, 0, 0,   0,  4, 15, 1, 1, 0, WAIT_NUMBER);
    add("g_digit_4",         1, 8'h25, 0, 0, 0,   0,  4,  4, 1, 1, 0, WAIT_CONFIRM);
    add("g_enter",           1, 8'h5A, 0, 0, 0,   1,  4,  4, 1, 1, 0, ISSUE);
    add("g_wait",            0, 8'h00, 0, 0, 0,   1,  4,  4, 1, 1, 0, ISSUE);
    add("g_gameover",        0, 8'h00, 0, 0, 1,   0,  4,  4, 1, 1, 0, LOCKED);
    add("g_esc_locked",      1, 8'h76, 0, 0, 0,   0,  4,  4, 1, 1, 0, LOCKED);
    add("g_ack_locked",      0, 8'h00, 1, 0, 0,   0,  4,  4, 1, 1, 0, LOCKED);
    add("g_enter_locked",    1, 8'h5A, 0, 0, 0,   0,  4,  4, 1, 1, 0, LOCKED);
    run_all();

    // Only reset leaves LOCKED.
    resetN = 1'b0;
    #1;
    check("h_reset_from_locked", 0, 15, 15, 0, 0, 0, WAIT_LETTER);
    @(posedge clock27);
    #1;
    resetN = 1'b1;

    add("h_release_key",     1, 8'h1C, 0, 0, 0,   0, 15, 15, 0, 0, 0, WAIT_LETTER);
    add("h_letter_e",        1, 8'h24, 0, 0, 0,   0,  4, 15, 0, 0, 0, WAIT_NUMBER);
    add("h_digit_5",         1, 8'h2E, 0, 0, 0,   0,  4,  5, 0, 0, 0, WAIT_CONFIRM);
    add("h_enter",           1, 8'h5A, 0, 0, 0,   1,  4,  5, 0, 0, 0, ISSUE);
    add("h_wait",            0, 8'h00, 0, 0, 0,   1,  4,  5, 0, 0, 0, ISSUE);
    run_all();

    // Asynchronous reset mid-ISSUE, between clock edges.
    #2;
    resetN = 1'b0;
    #1;
    check("r_async_reset", 0, 15, 15, 0, 0, 0, WAIT_LETTER);
    keyValid = 1'b1; keyCode = 8'h24;
    @(posedge clock27);
    #1;
    check("r_reset_held", 0, 15, 15, 0, 0, 0, WAIT_LETTER);
    resetN = 1'b1;
    add("r_release_key",     1, 8'h24, 0, 0, 0,   0, 15, 15, 0, 0, 0, WAIT_LETTER);
    add("r_letter_after",    1, 8'h24, 0, 0, 0,   0,  4, 15, 0, 0, 0, WAIT_NUMBER);
    run_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
